// File: rtl/instr_fetch_responder.sv
// rtl/instr_fetch_responder.sv - instruction fetch responder with fixed-latency in-order replies (optional stats: FETCH_STATS_EN)
module instr_fetch_responder #(
    parameter int MEM_DEPTH       = 256,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_instr_o,
    output logic [31:0] rsp_addr_o,
    output logic        rsp_err_o,
    input  logic        load_en_i,
    input  logic [31:0] load_addr_i,
    input  logic [31:0] load_data_i,
`ifdef FETCH_STATS_EN
    output logic [31:0] fetch_count_o,
    output logic [15:0] err_count_o,
`endif
    output logic        busy_o
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } rsp_t;

    logic [31:0]        mem_q [MEM_DEPTH];
    logic [LATENCY-1:0] pv_q;
    rsp_t               pd_q  [LATENCY];
    rsp_t               fifo_q[MAX_OUTSTANDING];
    logic [PW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]      fcnt_q, fcnt_d;
    logic [CW-1:0]      out_q, out_d;
    rsp_t               lookup;
    rsp_t               head;
    logic               accept, hs, push;
    logic               load_ok;

    assign req_ready_o = !reset_i && !load_en_i && (out_q < CW'(MAX_OUTSTANDING));
    assign accept      = req_valid_i && req_ready_o;
    assign hs          = rsp_valid_o && rsp_ready_i;
    assign push        = pv_q[LATENCY-1];
    assign load_ok     = load_en_i && (load_addr_i[1:0] == 2'b00)
                         && ({2'b00, load_addr_i[31:2]} < 32'(MEM_DEPTH));

    // RAM read at acceptance; bad addresses turn into an error response with a zero word
    always_comb begin
        lookup       = '0;
        lookup.addr  = req_addr_i;
        if (req_addr_i[1:0] == 2'b00 && {2'b00, req_addr_i[31:2]} < 32'(MEM_DEPTH)) begin
            lookup.instr = mem_q[req_addr_i[AW+1:2]];
        end else begin
            lookup.err = 1'b1;
        end
    end

    // Load port writes; the RAM is deliberately untouched by reset
    always_ff @(posedge clk_i) begin
        if (load_ok) begin
            mem_q[load_addr_i[AW+1:2]] <= load_data_i;
        end
    end

    // Fixed-latency delay line; it never stalls because credits reserve FIFO space
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= accept;
            pd_q[0] <= lookup;
            for (int i = 1; i < LATENCY; i++) begin
                pv_q[i] <= pv_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
        end
    end

    // Next-state for FIFO occupancy and outstanding credits
    always_comb begin
        fcnt_d = fcnt_q + CW'(push) - CW'(hs);
        out_d  = out_q + CW'(accept) - CW'(hs);
    end

    // Response FIFO storage; head drives the response outputs
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= pd_q[LATENCY-1];
        end
    end

    // FIFO pointers, occupancy and outstanding counter
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            fcnt_q   <= '0;
            out_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (hs)   rd_ptr_q <= rd_ptr_q + 1'b1;
            fcnt_q <= fcnt_d;
            out_q  <= out_d;
        end
    end

    assign head        = fifo_q[rd_ptr_q];
    assign rsp_valid_o = !reset_i && (fcnt_q != '0);
    assign rsp_instr_o = reset_i ? 32'h0 : head.instr;
    assign rsp_addr_o  = reset_i ? 32'h0 : head.addr;
    assign rsp_err_o   = reset_i ? 1'b0  : head.err;
    assign busy_o      = !reset_i && (out_q != '0);

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q;
    logic [15:0] err_count_q;

    // Handshake counters; the error count sticks at its maximum
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_count_q <= '0;
            err_count_q   <= '0;
        end else if (hs) begin
            fetch_count_q <= fetch_count_q + 32'd1;
            if (rsp_err_o && err_count_q != 16'hFFFF) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    assign fetch_count_o = fetch_count_q;
    assign err_count_o   = err_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_responder.sv
// tb/tb_instr_fetch_responder.sv - randomized self-checking bench for instr_fetch_responder
module tb_instr_fetch_responder;

    localparam int L  = 2;
    localparam int MO = 4;
    localparam int D  = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic        rsp_err;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'h0;
    logic [31:0] load_data = 32'h0;
    logic        busy;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
    logic [15:0] err_count;
`endif

    always #5 clk = ~clk;

    instr_fetch_responder #(.MEM_DEPTH(D), .LATENCY(L), .MAX_OUTSTANDING(MO)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_instr_o(rsp_instr), .rsp_addr_o(rsp_addr), .rsp_err_o(rsp_err),
        .load_en_i(load_en), .load_addr_i(load_addr), .load_data_i(load_data),
`ifdef FETCH_STATS_EN
        .fetch_count_o(fetch_count), .err_count_o(err_count),
`endif
        .busy_o(busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] i;
        logic        e;
        int          t;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_m[D];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errs = 0;
    longint      fc_m = 0;
    int          ec_m = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: drive inputs, compare outputs against the queue model, advance the model
    task automatic step(input logic rv, input logic [31:0] ra, input logic rr,
                        input logic le, input logic [31:0] la, input logic [31:0] ld,
                        input logic rst);
        logic er, ev;
        exp_t n;
        @(negedge clk);
        reset = rst; req_valid = rv; req_addr = ra; rsp_ready = rr;
        load_en = le; load_addr = la; load_data = ld;
        #1;
        er = !rst && !le && (q.size() < MO);
        ev = !rst && (q.size() > 0) && (cyc >= q[0].t + L);
        check("req_ready", 64'(req_ready), 64'(er));
        check("rsp_valid", 64'(rsp_valid), 64'(ev));
        check("busy", 64'(busy), 64'(!rst && q.size() != 0));
        if (rst) begin
            check("rst_instr", 64'(rsp_instr), 64'h0);
            check("rst_addr", 64'(rsp_addr), 64'h0);
            check("rst_err", 64'(rsp_err), 64'h0);
        end else if (ev) begin
            check("rsp_instr", 64'(rsp_instr), 64'(q[0].i));
            check("rsp_addr", 64'(rsp_addr), 64'(q[0].a));
            check("rsp_err", 64'(rsp_err), 64'(q[0].e));
        end
`ifdef FETCH_STATS_EN
        if (!rst) begin
            check("fetch_count", 64'(fetch_count), 64'(fc_m));
            check("err_count", 64'(err_count), 64'(ec_m));
        end
`endif
        if (rst) begin
            q.delete();
            fc_m = 0;
            ec_m = 0;
        end else begin
            if (ev && rr) begin
                fc_m++;
                if (q[0].e && ec_m < 65535) ec_m++;
                void'(q.pop_front());
            end
            if (er && rv) begin
                n.a = ra;
                n.t = cyc + 1;
                if (ra[1:0] == 2'b00 && ra[31:2] < D) begin
                    n.e = 1'b0;
                    n.i = mem_m[ra[31:2]];
                end else begin
                    n.e = 1'b1;
                    n.i = 32'h0;
                end
                q.push_back(n);
            end
            if (le && la[1:0] == 2'b00 && la[31:2] < D) mem_m[la[31:2]] = ld;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, rr, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic load(input logic [31:0] la, input logic [31:0] ld);
        step(1'b0, 32'h0, 1'b1, 1'b1, la, ld, 1'b0);
    endtask

    task automatic fetch(input logic [31:0] ra, input logic rr);
        step(1'b1, ra, rr, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] prog[4];
        logic [31:0] a;
        int          kind;
        prog[0] = 32'hE3A00001; prog[1] = 32'hE3A01002;
        prog[2] = 32'hE0802001; prog[3] = 32'hEAFFFFFE;

        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(1, 1'b0);

        for (int k = 0; k < D; k++) load(32'(k * 4), $urandom);
        for (int k = 0; k < 4; k++) load(32'(k * 4), prog[k]);
        load(32'h0000_0401, 32'hDEAD_BEEF);
        load(32'h0000_0802, 32'hDEAD_BEEF);

        for (int k = 0; k < 4; k++) fetch(32'(k * 4), 1'b1);
        idle(6, 1'b1);

        for (int k = 0; k < 6; k++) fetch(32'(k * 4), 1'b0);
        idle(2, 1'b0);
        idle(8, 1'b1);

        fetch(32'h0000_0002, 1'b1);
        fetch(32'h0000_0400, 1'b1);
        idle(5, 1'b1);

        fetch(32'h0000_0010, 1'b0);
        fetch(32'h0000_0014, 1'b0);
        idle(3, 1'b0);
        idle(4, 1'b1);

        step(1'b1, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0);
        fetch(32'h0000_0020, 1'b1);
        idle(4, 1'b1);

        for (int k = 0; k < 3; k++) fetch(32'(k * 4), 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        idle(6, 1'b1);

        for (int k = 0; k < 800; k++) begin
            kind = int'($urandom_range(0, 9));
            a    = {22'h0, 8'($urandom), 2'b00};
            if (kind == 0) a = a | 32'($urandom_range(1, 3));
            else if (kind == 1) a = 32'h400 + {20'h0, 10'($urandom), 2'b00};
            step($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, {22'h0, 8'($urandom), 2'($urandom_range(0, 4) == 0)},
                 $urandom, $urandom_range(0, 199) == 0);
        end
        idle(12, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Instruction-memory responder on the CPU side of the fetch interface. The pipeline's IF stage issues PC requests; this block answers each with the instruction word.
- Internal word-addressed instruction RAM, preloaded through a load port by the bench or boot logic.
- Fixed, configurable read latency. Multiple outstanding requests. Responses returned in order, with valid/ready backpressure on both sides.

Parameters:
- MEM_DEPTH, 256, instruction words stored; index = addr[31:2].
- LATENCY, 2, minimum cycles from request acceptance to rsp_valid; legal range 1..8.
- MAX_OUTSTANDING, 4, maximum accepted-but-unreturned requests; power of 2, at least 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  fetch request present
- req_ready  out  1  block can accept a request this cycle
- req_addr  in  32  byte address (PC)
- rsp_valid  out  1  response present
- rsp_ready  in  1  IF stage consumes the response
- rsp_instr  out  32  instruction word; 32'h0 on error
- rsp_addr  out  32  echo of the request address
- rsp_err  out  1  misaligned or out-of-range address
- load_en  in  1  write one word into the instruction RAM
- load_addr  in  32  byte address for the load
- load_data  in  32  word to write
- busy  out  1  outstanding count is nonzero

Behaviour:
- Reset:
  - Clears the delay pipeline, response FIFO and outstanding counter.
  - Output values during reset: req_ready=0, rsp_valid=0, rsp_instr=0, rsp_addr=0, rsp_err=0, busy=0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all in-flight requests; no response for them ever appears.
- Accept: a request is accepted when req_valid && req_ready.
- req_ready = !reset && !load_en && (outstanding < MAX_OUTSTANDING).
  - Combinational from registered state plus load_en.
  - Never depends on req_valid.
- Outstanding counter:
  - +1 on accept; -1 on response handshake (rsp_valid && rsp_ready).
  - Both in the same cycle: unchanged.
  - The credit limit guarantees the FIFO never overflows.
- Lookup at acceptance:
  - addr[1:0] != 0: err=1, instr=0.
  - addr[31:2] >= MEM_DEPTH: err=1, instr=0.
  - Otherwise: err=0, instr=RAM[addr[31:2]].
- Delay and queueing:
  - {instr, addr, err} travel through a LATENCY-stage shift register of valid-tagged slots.
  - They then enter a MAX_OUTSTANDING-deep FIFO whose head drives the rsp_* outputs.
- Latency:
  - A request accepted on edge N with an empty FIFO shows rsp_valid=1 after edge N+LATENCY.
  - Back-to-back accepts with rsp_ready=1 give one response per cycle.
- Stall:
  - While rsp_valid && !rsp_ready, rsp_instr, rsp_addr and rsp_err hold stable.
  - The delay pipeline keeps draining into the FIFO, which has space by the credit argument.
- FIFO:
  - Simultaneous push and pop on a full or empty FIFO are both legal.
  - Pop of the head and push of the tail occur in the same cycle.
  - An empty FIFO with a push does not bypass: data appears the next cycle, already counted in LATENCY.
- Order: responses always leave in acceptance order.
- Load port:
  - load_en writes RAM[load_addr[31:2]] on the edge.
  - Out-of-range or misaligned load_addr: the write is ignored.
  - load_en forces req_ready=0. In-flight responses still drain.
  - A read never sees a same-cycle load, because requests are blocked during loads.
- busy = (outstanding != 0).

Optional Feature:
- FETCH_STATS_EN.
- Defined: adds output fetch_count[31:0] and output err_count[15:0].
  - fetch_count increments on every response handshake.
  - err_count increments on each handshake with rsp_err=1 and saturates at 16'hFFFF.
  - Both clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Preload RAM[0..3] = 32'hE3A00001, 32'hE3A01002, 32'hE0802001, 32'hEAFFFFFE. Then issue PC = 0, 4, 8, 12 back-to-back with rsp_ready=1, LATENCY=2.
  -> Responses arrive on 4 consecutive cycles, the first 2 cycles after the first accept, in order, rsp_err=0.
- Issue 6 requests with rsp_ready=0 (MAX_OUTSTANDING=4).
  -> req_ready drops after the 4th accept and busy=1.
  -> After rsp_ready=1, exactly 4 in-order responses appear, then req_ready returns.
- Request addr 32'h2 and addr 32'h400 (MEM_DEPTH=256).
  -> Both return rsp_err=1, rsp_instr=0, rsp_addr echoed.
  -> With FETCH_STATS_EN: err_count=2.
- Hold rsp_ready=0 for 3 cycles while rsp_valid=1.
  -> rsp_instr, rsp_addr and rsp_err are unchanged on every cycle. Then one handshake per cycle.
- Assert load_en for one cycle while req_valid=1.
  -> req_ready=0 that cycle, no accept, the word is written.
  -> A following fetch of that address returns the new data.
- Assert reset with 3 requests in flight.
  -> The next cycle shows rsp_valid=0, busy=0, req_ready=0. The old responses never appear after reset is released.
